// File: rtl/jtpang_objbuf_if.sv
// Sprite draw engine to object line buffer handshake: sliver request and busy.
interface jtpang_objbuf_if #(
  parameter int unsigned AW = 9
);
  logic          draw_req;
  logic [AW-1:0] draw_x;
  logic [3:0]    draw_pal;
  logic          draw_hflip;
  logic [31:0]   draw_data;
  logic          draw_busy;

  modport master (
    output draw_req, draw_x, draw_pal, draw_hflip, draw_data,
    input  draw_busy
  );

  modport slave (
    input  draw_req, draw_x, draw_pal, draw_hflip, draw_data,
    output draw_busy
  );
endinterface

// File: rtl/jtpang_objbuf.sv
// Double-banked object line buffer: draws 8-pixel slivers into one bank while scanning out the other.
// Optional macro JTPANG_OBJ_FIRSTWIN_EN: read-before-write so the first opaque pixel drawn wins.
module jtpang_objbuf #(
  parameter int unsigned AW = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pxl_cen,
  input  logic                LHBL,
  input  logic [AW-1:0]       hdump,
  jtpang_objbuf_if.slave      drw,
  output logic [7:0]          obj_pxl
);

  localparam int unsigned DEPTH = 1 << AW;
`ifdef JTPANG_OBJ_FIRSTWIN_EN
  localparam int unsigned DCYC  = 16;
`else
  localparam int unsigned DCYC  = 8;
`endif
  localparam logic [AW-1:0] CLR_LAST  = AW'(DEPTH - 1);
  localparam logic [AW-1:0] DRAW_LAST = AW'(DCYC - 1);
  localparam logic [7:0]    BLANK     = 8'hFF;

  typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_DRAW} state_t;

  state_t        state, state_nx;
  logic [AW-1:0] cnt, cnt_nx;
  logic          bank, bank_nx, lhbl_q, swap;
  logic          accept;

  logic [AW-1:0] lat_x;
  logic [3:0]    lat_pal;
  logic          lat_hflip;
  logic [31:0]   lat_data;
  logic          lat_bank;

  logic [2:0]    idx, sel;
  logic [3:0]    nib;
  logic [AW-1:0] drw_addr;
  logic          wr_phase, drw_we, clr_we;

  logic          ers_we, ers_bank;
  logic [AW-1:0] ers_addr;

  logic [7:0]    mem_a [DEPTH];
  logic [7:0]    mem_b [DEPTH];

  // A swap on the same edge as a request must steer the sliver to the new back bank
  assign swap    = lhbl_q & ~LHBL;
  assign bank_nx = bank ^ swap;
  assign accept  = (state == ST_IDLE) & drw.draw_req & ~drw.draw_busy;

`ifdef JTPANG_OBJ_FIRSTWIN_EN
  logic [7:0] rd_q;
  assign idx      = cnt[3:1];
  assign wr_phase = cnt[0];
`else
  assign idx      = cnt[2:0];
  assign wr_phase = 1'b1;
`endif

  assign sel      = lat_hflip ? (3'd7 - idx) : idx;
  assign nib      = lat_data[{sel, 2'b00} +: 4];
  assign drw_addr = lat_x + AW'(idx);
  assign clr_we   = (state == ST_CLEAR) & ~rst;

`ifdef JTPANG_OBJ_FIRSTWIN_EN
  assign drw_we = (state == ST_DRAW) & wr_phase & (nib != 4'hF) & (rd_q[3:0] == 4'hF) & ~rst;
`else
  assign drw_we = (state == ST_DRAW) & wr_phase & (nib != 4'hF) & ~rst;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_CLEAR;
      cnt           <= '0;
      drw.draw_busy <= 1'b1;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      drw.draw_busy <= (state_nx != ST_IDLE);
    end
  end

  // Next state: CLEAR sweeps every address, DRAW walks the sliver pixels
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      ST_CLEAR: begin
        cnt_nx = cnt + AW'(1);
        if (cnt == CLR_LAST) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end
      end
      ST_IDLE: begin
        if (accept) begin
          state_nx = ST_DRAW;
          cnt_nx   = '0;
        end
      end
      ST_DRAW: begin
        cnt_nx = cnt + AW'(1);
        if (cnt == DRAW_LAST) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = ST_CLEAR;
        cnt_nx   = '0;
      end
    endcase
  end

  // Sliver capture and bank select
  always_ff @(posedge clk) begin
    if (rst) begin
      bank      <= 1'b0;
      lhbl_q    <= 1'b0;
      lat_x     <= '0;
      lat_pal   <= '0;
      lat_hflip <= 1'b0;
      lat_data  <= '0;
      lat_bank  <= 1'b0;
    end else begin
      lhbl_q <= LHBL;
      bank   <= bank_nx;
      if (accept) begin
        lat_x     <= drw.draw_x;
        lat_pal   <= drw.draw_pal;
        lat_hflip <= drw.draw_hflip;
        lat_data  <= drw.draw_data;
        lat_bank  <= ~bank_nx;
      end
    end
  end

  // Scan-out with erase-after-read on the following clk
  always_ff @(posedge clk) begin
    if (rst) begin
      obj_pxl  <= BLANK;
      ers_we   <= 1'b0;
      ers_bank <= 1'b0;
      ers_addr <= '0;
    end else begin
      ers_we <= 1'b0;
      if (pxl_cen) begin
        if (LHBL && state != ST_CLEAR) begin
          obj_pxl  <= bank ? mem_b[hdump] : mem_a[hdump];
          ers_we   <= 1'b1;
          ers_bank <= bank;
          ers_addr <= hdump;
        end else begin
          obj_pxl <= BLANK;
        end
      end
    end
  end

`ifdef JTPANG_OBJ_FIRSTWIN_EN
  // Even DRAW cycles fetch the target location, odd cycles decide the write
  always_ff @(posedge clk) begin
    rd_q <= lat_bank ? mem_b[drw_addr] : mem_a[drw_addr];
  end
`endif

  // Bank storage; the draw write is issued last so it wins an equal address
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_a[cnt] <= BLANK;
      mem_b[cnt] <= BLANK;
    end else begin
      if (ers_we && !ers_bank) mem_a[ers_addr] <= BLANK;
      if (ers_we &&  ers_bank) mem_b[ers_addr] <= BLANK;
      if (drw_we && !lat_bank) mem_a[drw_addr] <= {lat_pal, nib};
      if (drw_we &&  lat_bank) mem_b[drw_addr] <= {lat_pal, nib};
    end
  end

endmodule

// File: tb/tb_jtpang_objbuf.sv
// Directed bench for jtpang_objbuf: reset sweep, sliver vectors, overlap, mid-draw swap and reset.
module tb_jtpang_objbuf;
  localparam int unsigned AW = 9;
`ifdef JTPANG_OBJ_FIRSTWIN_EN
  localparam int         DRAW_LEN = 16;
  localparam logic [3:0] OV_PAL   = 4'h1;
`else
  localparam int         DRAW_LEN = 8;
  localparam logic [3:0] OV_PAL   = 4'h2;
`endif

  logic          clk = 1'b0;
  logic          rst, pxl_cen, LHBL;
  logic [AW-1:0] hdump;
  logic [7:0]    obj_pxl;
  int            checks = 0;
  int            errors = 0;

  jtpang_objbuf_if #(.AW(AW)) dif ();

  jtpang_objbuf #(.AW(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .pxl_cen (pxl_cen),
    .LHBL    (LHBL),
    .hdump   (hdump),
    .drw     (dif),
    .obj_pxl (obj_pxl)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] x;
    logic [3:0]    pal;
    logic          hf;
    logic [31:0]   data;
    logic [AW-1:0] col0;
    logic [7:0]    exp [10];
  } vec_t;

  vec_t vecs [4];

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (dif.draw_busy !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL %s: draw_busy still %b after %0d cycles", name, dif.draw_busy, n);
    end
  endtask

  task automatic draw(input logic [AW-1:0] x, input logic [3:0] pal, input logic hf,
                      input logic [31:0] data);
    wait_idle("pre_draw");
    dif.draw_req   = 1'b1;
    dif.draw_x     = x;
    dif.draw_pal   = pal;
    dif.draw_hflip = hf;
    dif.draw_data  = data;
    @(negedge clk);
    dif.draw_req   = 1'b0;
  endtask

  task automatic scan_col(input logic [AW-1:0] h, output logic [7:0] v);
    hdump   = h;
    pxl_cen = 1'b1;
    @(negedge clk);
    pxl_cen = 1'b0;
    v       = obj_pxl;
    @(negedge clk);
  endtask

  task automatic swap_line();
    LHBL = 1'b0;
    @(negedge clk);
    pxl_cen = 1'b1;
    @(negedge clk);
    pxl_cen = 1'b0;
    check8("blank_pxl", obj_pxl, 8'hFF);
    repeat (2) @(negedge clk);
    LHBL = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0]    got;
    logic [AW-1:0] col;
    int            bad, busy_cnt, n;

    vecs[0] = '{x: 9'd100, pal: 4'h3, hf: 1'b0, data: 32'h7654_3210, col0: 9'd99,
                exp: '{8'hFF, 8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'hFF}};
    vecs[1] = '{x: 9'd10, pal: 4'h5, hf: 1'b1, data: 32'hF000_000A, col0: 9'd9,
                exp: '{8'hFF, 8'hFF, 8'h50, 8'h50, 8'h50, 8'h50, 8'h50, 8'h50, 8'h5A, 8'hFF}};
    vecs[2] = '{x: 9'd510, pal: 4'h7, hf: 1'b0, data: 32'h1234_5678, col0: 9'd508,
                exp: '{8'hFF, 8'hFF, 8'h78, 8'h77, 8'h76, 8'h75, 8'h74, 8'h73, 8'h72, 8'h71}};
    vecs[3] = '{x: 9'd200, pal: 4'hA, hf: 1'b1, data: 32'h0123_4567, col0: 9'd199,
                exp: '{8'hFF, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hFF}};

    rst            = 1'b1;
    pxl_cen        = 1'b0;
    LHBL           = 1'b1;
    hdump          = '0;
    dif.draw_req   = 1'b0;
    dif.draw_x     = '0;
    dif.draw_pal   = '0;
    dif.draw_hflip = 1'b0;
    dif.draw_data  = '0;

    // Reset and CLEAR sweep
    repeat (3) @(negedge clk);
    check8("rst_pxl", obj_pxl, 8'hFF);
    check_int("rst_busy", int'(dif.draw_busy), 1);
    rst      = 1'b0;
    busy_cnt = 0;
    bad      = 0;
    n        = 0;
    while (dif.draw_busy === 1'b1 && n < 2000) begin
      busy_cnt++;
      if (obj_pxl !== 8'hFF) bad++;
      pxl_cen = n[0];
      hdump   = AW'(n);
      @(negedge clk);
      n++;
    end
    pxl_cen = 1'b0;
    @(negedge clk);
    check_int("clear_len", busy_cnt, 512);
    check_int("clear_pxl_bad", bad, 0);

    bad = 0;
    for (int h = 0; h < 512; h++) begin
      scan_col(AW'(h), got);
      if (got !== 8'hFF) bad++;
    end
    check_int("line0_bad", bad, 0);

    // Table-driven slivers: draw, swap, read, then re-read the same bank to prove erase
    for (int v = 0; v < 4; v++) begin
      draw(vecs[v].x, vecs[v].pal, vecs[v].hf, vecs[v].data);
      wait_idle("draw_done");
      swap_line();
      for (int k = 0; k < 10; k++) begin
        col = AW'(int'(vecs[v].col0) + k);
        scan_col(col, got);
        check8($sformatf("v%0d_col%0d", v, col), got, vecs[v].exp[k]);
      end
      swap_line();
      swap_line();
      for (int k = 0; k < 10; k++) begin
        col = AW'(int'(vecs[v].col0) + k);
        scan_col(col, got);
        check8($sformatf("v%0d_erase%0d", v, col), got, 8'hFF);
      end
    end

    // Overlap at x=50 and DRAW length
    draw(9'd50, 4'h1, 1'b0, 32'h7654_3210);
    draw(9'd50, 4'h2, 1'b0, 32'h7654_3210);
    busy_cnt = 0;
    while (dif.draw_busy === 1'b1 && busy_cnt < 100) begin
      busy_cnt++;
      @(negedge clk);
    end
    check_int("draw_len", busy_cnt, DRAW_LEN);
    swap_line();
    for (int k = 0; k < 8; k++) begin
      scan_col(AW'(50 + k), got);
      check8($sformatf("ovl_col%0d", 50 + k), got, {OV_PAL, 4'(k)});
    end

    // LHBL falls mid-draw: sliver completes into the bank latched at start
    draw(9'd300, 4'h4, 1'b0, 32'h7654_3210);
    repeat (3) @(negedge clk);
    LHBL = 1'b0;
    repeat (3) @(negedge clk);
    LHBL = 1'b1;
    wait_idle("mid_swap_done");
    @(negedge clk);
    for (int k = 0; k < 9; k++) begin
      scan_col(AW'(300 + k), got);
      check8($sformatf("mswap_col%0d", 300 + k), got, (k < 8) ? {4'h4, 4'(k)} : 8'hFF);
    end

    // Reset mid-draw restarts CLEAR and wipes the partial sliver
    draw(9'd400, 4'h6, 1'b0, 32'h7654_3210);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_int("mrst_busy", int'(dif.draw_busy), 1);
    check8("mrst_pxl", obj_pxl, 8'hFF);
    wait_idle("mrst_clear");
    for (int s = 0; s < 2; s++) begin
      swap_line();
      bad = 0;
      for (int k = 0; k < 8; k++) begin
        scan_col(AW'(400 + k), got);
        if (got !== 8'hFF) bad++;
      end
      check_int($sformatf("mrst_line%0d_bad", s), bad, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
